// File: rtl/rk_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rk_spi_pkg
// Purpose  : Register offsets, mode constants and hardware-FSM state encoding
//            shared by the rk_spi_port block.
// Revision : 1.0 - initial release
// ============================================================================
package rk_spi_pkg;

  localparam logic [1:0] REG_CS   = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  localparam logic MODE_LEGACY = 1'b0;
  localparam logic MODE_HW     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/rk_spi_port_if.sv
`default_nettype none
// ============================================================================
// Module   : rk_spi_port_if
// Purpose  : CPU-side register bus of the SPI port (decoded 0xA000 window).
// Revision : 1.0 - initial release
// ============================================================================
interface rk_spi_port_if;

  logic [1:0] addr;
  logic       we_n;
  logic       bus_rd;
  logic [7:0] idata;
  logic [7:0] odata;
  logic       busy;
  logic       irq;

  modport master (output addr, we_n, bus_rd, idata, input  odata, busy, irq);
  modport slave  (input  addr, we_n, bus_rd, idata, output odata, busy, irq);

endinterface
`default_nettype wire

// File: rtl/rk_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : rk_spi_shifter
// Purpose  : Hardware byte-mode engine: SCK divider, bit FSM and tx/rx shift
//            registers (SPI mode 0, MSB first).
// Revision : 1.0 - initial release
// ============================================================================
module rk_spi_shifter
  import rk_spi_pkg::*;
(
  input  wire logic       clk50mhz,
  input  wire logic       reset,
  input  wire logic       i_start,
  input  wire logic [7:0] i_tx,
  input  wire logic [7:0] i_div,
  input  wire logic       i_miso,
  input  wire logic       i_clr_done,
  output logic            o_sck,
  output logic            o_mosi,
  output logic            o_busy,
  output logic            o_done,
  output logic [7:0]      o_rx
);

  spi_state_t r_state, w_state;
  logic [7:0] r_cnt,    w_cnt;
  logic [2:0] r_bitcnt, w_bitcnt;
  logic [7:0] r_tx,     w_tx;
  logic [7:0] r_rx,     w_rx;
  logic       r_sck,    w_sck;
  logic       r_mosi,   w_mosi;
  logic       r_done,   w_done;

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_bitcnt <= 3'd0;
      r_tx     <= 8'd0;
      r_rx     <= 8'd0;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_bitcnt <= w_bitcnt;
      r_tx     <= w_tx;
      r_rx     <= w_rx;
      r_sck    <= w_sck;
      r_mosi   <= w_mosi;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bitcnt = r_bitcnt;
    w_tx     = r_tx;
    w_rx     = r_rx;
    w_sck    = r_sck;
    w_mosi   = r_mosi;
    w_done   = r_done & ~i_clr_done;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_tx     = i_tx;
          w_mosi   = i_tx[7];
          w_bitcnt = 3'd0;
          w_cnt    = i_div;
          w_done   = 1'b0;
          w_state  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_cnt == 8'd0) begin
          w_sck   = 1'b1;
          w_rx    = {r_rx[6:0], i_miso};
          w_cnt   = i_div;
          w_state = ST_HIGH;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      ST_HIGH: begin
        if (r_cnt == 8'd0) begin
          w_sck = 1'b0;
          w_cnt = i_div;
          if (r_bitcnt == 3'd7) begin
            w_done  = 1'b1;
            w_state = ST_IDLE;
          end else begin
            // Next bit goes out on the falling edge, ahead of the next rise.
            w_bitcnt = r_bitcnt + 3'd1;
            w_mosi   = r_tx[3'd6 - r_bitcnt];
            w_state  = ST_LOW;
          end
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign o_sck  = r_sck;
  assign o_mosi = r_mosi;
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;
  assign o_rx   = r_rx;

endmodule
`default_nettype wire

// File: rtl/rk_spi_port.sv
`default_nettype none
// ============================================================================
// Module   : rk_spi_port
// Purpose  : SPI master for the 0xA000 window: legacy bit-bang SD interface
//            plus hardware byte mode. Optional macro RK_SPI_IRQ_EN adds a
//            transfer-done interrupt enabled by CTRL bit1.
// Revision : 1.0 - initial release
// ============================================================================
module rk_spi_port
  import rk_spi_pkg::*;
#(
  parameter int         CS_COUNT  = 1,
  parameter logic [7:0] DIV_RESET = 8'd24
) (
  input  wire logic           clk50mhz,
  input  wire logic           reset,
  rk_spi_port_if.slave        bus,
  input  wire logic           spi_miso,
  output logic                spi_mosi,
  output logic                spi_sck,
  output logic [CS_COUNT-1:0] spi_cs_n
);

  logic                r_mode;
  logic [7:0]          r_div;
  logic [CS_COUNT-1:0] r_cs;
  logic                r_sck_leg;
  logic                r_mosi_leg;
  logic [6:0]          r_lshift;

  logic       w_wr;
  logic       w_busy;
  logic       w_done;
  logic       w_hw_sck;
  logic       w_hw_mosi;
  logic [7:0] w_rx;
  logic       w_start;
  logic       w_clr_done;
  logic       w_ien;
  logic [3:0] w_cs4;

  assign w_wr       = ~bus.we_n;
  assign w_start    = w_wr & (bus.addr == REG_DATA) & (r_mode == MODE_HW);
  assign w_clr_done = bus.bus_rd & (bus.addr == REG_DATA) & (r_mode == MODE_HW);

`ifdef RK_SPI_IRQ_EN
  logic r_ien;
  assign w_ien   = r_ien;
  assign bus.irq = w_done & r_ien;
`else
  assign w_ien   = 1'b0;
  assign bus.irq = 1'b0;
`endif

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      r_mode     <= MODE_LEGACY;
      r_div      <= DIV_RESET;
      r_cs       <= '0;
      r_sck_leg  <= 1'b0;
      r_mosi_leg <= 1'b1;
      r_lshift   <= 7'd0;
`ifdef RK_SPI_IRQ_EN
      r_ien      <= 1'b0;
`endif
    end else if (w_wr) begin
      case (bus.addr)
        REG_CS: r_cs <= bus.idata[CS_COUNT-1:0];
        REG_DATA: begin
          // The sck test makes a repeated strobe shift only once.
          if (r_mode == MODE_LEGACY) begin
            r_mosi_leg <= bus.idata[7];
            r_sck_leg  <= 1'b0;
            if (r_sck_leg) r_lshift <= {r_lshift[5:0], spi_miso};
          end
        end
        REG_CTRL: begin
          if (!w_busy) begin
            r_mode    <= bus.idata[0];
            r_sck_leg <= 1'b0;
`ifdef RK_SPI_IRQ_EN
            r_ien     <= bus.idata[1];
`endif
          end
        end
        REG_DIV: if (!w_busy) r_div <= bus.idata;
        default: ;
      endcase
    end else if (bus.bus_rd && r_mode == MODE_LEGACY) begin
      r_sck_leg <= 1'b1;
    end
  end

  rk_spi_shifter u_shifter (
    .clk50mhz   (clk50mhz),
    .reset      (reset),
    .i_start    (w_start),
    .i_tx       (bus.idata),
    .i_div      (r_div),
    .i_miso     (spi_miso),
    .i_clr_done (w_clr_done),
    .o_sck      (w_hw_sck),
    .o_mosi     (w_hw_mosi),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_rx       (w_rx)
  );

  always_comb begin
    w_cs4               = 4'd0;
    w_cs4[CS_COUNT-1:0] = r_cs;
  end

  always_comb begin
    bus.odata = 8'h00;
    case (bus.addr)
      REG_CS:   bus.odata = {w_busy, r_mode, w_done, 1'b0, w_cs4};
      REG_DATA: bus.odata = (r_mode == MODE_HW) ? w_rx : {r_lshift, spi_miso};
      REG_CTRL: bus.odata = {6'd0, w_ien, r_mode};
      REG_DIV:  bus.odata = r_div;
      default:  bus.odata = 8'h00;
    endcase
  end

  assign bus.busy = w_busy;
  assign spi_sck  = (r_mode == MODE_HW) ? w_hw_sck  : r_sck_leg;
  assign spi_mosi = (r_mode == MODE_HW) ? w_hw_mosi : r_mosi_leg;
  assign spi_cs_n = ~r_cs;

endmodule
`default_nettype wire

// File: tb/tb_rk_spi_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_rk_spi_port
// Purpose  : Directed + randomized self-checking bench for rk_spi_port with a
//            behavioural SPI slave and register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rk_spi_port;
  import rk_spi_pkg::*;

  localparam int NCS = 2;
`ifdef RK_SPI_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic           clk50mhz = 1'b0;
  logic           reset;
  logic           spi_miso;
  logic           spi_mosi;
  logic           spi_sck;
  logic [NCS-1:0] spi_cs_n;

  rk_spi_port_if bus_if ();

  rk_spi_port #(.CS_COUNT(NCS), .DIV_RESET(8'd24)) dut (
    .clk50mhz (clk50mhz),
    .reset    (reset),
    .bus      (bus_if),
    .spi_miso (spi_miso),
    .spi_mosi (spi_mosi),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n)
  );

  always #10 clk50mhz = ~clk50mhz;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc        = 0;
  int unsigned rise_total = 0;
  int unsigned rise_base;
  int unsigned k;
  logic [7:0]  slave_rx;
  logic [7:0]  slave_tx;
  logic [1:0]  miso_sel;
  logic        miso_bit;
  logic [3:0]  cur_cs;

  always @(posedge clk50mhz) cyc <= cyc + 1;

  // Mode-0 slave: captures mosi on each rising SCK, presents slave_tx MSB first.
  always @(posedge spi_sck) begin
    rise_total <= rise_total + 1;
    slave_rx   <= {slave_rx[6:0], spi_mosi};
  end

  always_comb begin
    k        = rise_total - rise_base;
    spi_miso = miso_bit;
    if (miso_sel == 2'd1)      spi_miso = (k < 8) ? slave_tx[3'(7 - k)] : 1'b1;
    else if (miso_sel == 2'd2) spi_miso = spi_mosi;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_if.addr  = a;
    bus_if.idata = d;
    bus_if.we_n  = 1'b0;
    @(posedge clk50mhz); #1;
    bus_if.we_n  = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus_if.addr   = a;
    bus_if.bus_rd = 1'b1;
    #1 d = bus_if.odata;
    @(posedge clk50mhz); #1;
    bus_if.bus_rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int unsigned t_end);
    int guard = 0;
    while (bus_if.busy === 1'b1 && guard < 20000) begin
      @(posedge clk50mhz); #1;
      guard++;
    end
    t_end = cyc;
    if (guard >= 20000) chk({tag, "_timeout"}, 32'(bus_if.busy), 32'd0);
  endtask

  task automatic hw_xfer(input string tag, input logic [7:0] dv, input logic [7:0] tx,
                         input logic [7:0] m, input bit loopback, input bit exp_irq);
    int unsigned t0, t1;
    logic [7:0]  v;
    rise_base = rise_total;
    slave_tx  = m;
    miso_sel  = loopback ? 2'd2 : 2'd1;
    wr(REG_DATA, tx);
    t0 = cyc;
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
    wait_idle(tag, t1);
    chk({tag, "_cycles"}, t1 - t0, 32'(16 * (int'(dv) + 1)));
    chk({tag, "_pulses"}, rise_total - rise_base, 32'd8);
    chk({tag, "_mosi"}, 32'(slave_rx), 32'(tx));
    chk({tag, "_irq"}, 32'(bus_if.irq), 32'(exp_irq));
    rd(REG_CS, v);
    chk({tag, "_cs_done"}, 32'(v), 32'({3'b011, 1'b0, cur_cs}));
    rd(REG_DATA, v);
    chk({tag, "_rx"}, 32'(v), 32'(loopback ? tx : m));
    chk({tag, "_irq_clr"}, 32'(bus_if.irq), 32'd0);
    rd(REG_CS, v);
    chk({tag, "_done_clr"}, 32'(v[5]), 32'd0);
    miso_sel = 2'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v, d, m, dv, last_rx;
    logic [6:0]  m_lsh;
    bit          m_sck;
    int unsigned t0, t1;

    reset = 1'b1;
    bus_if.addr = 2'd0; bus_if.we_n = 1'b1; bus_if.bus_rd = 1'b0; bus_if.idata = 8'h00;
    miso_sel = 2'd0; miso_bit = 1'b1; rise_base = 0; slave_tx = 8'h00; cur_cs = 4'd0;
    m_lsh = 7'd0; m_sck = 1'b0;
    repeat (3) @(posedge clk50mhz);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_sck",  32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd1);
    chk("rst_cs_n", 32'(spi_cs_n), 32'h3);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_irq",  32'(bus_if.irq), 32'd0);
    rd(REG_CS, v);   chk("rst_rd_cs", 32'(v), 32'h00);
    rd(REG_CTRL, v); chk("rst_rd_ctrl", 32'(v), 32'h00);
    rd(REG_DIV, v);  chk("rst_rd_div", 32'(v), 32'd24);
    rd(REG_DATA, v); chk("rst_rd_data", 32'(v), 32'h01);
    m_sck = 1'b1;

    // Legacy bit-bang: write bit7 out, bus_rd raises sck, next write samples miso
    wr(REG_DATA, 8'h80);
    if (m_sck) m_lsh = {m_lsh[5:0], miso_bit};
    m_sck = 1'b0;
    chk("leg_mosi0", 32'(spi_mosi), 32'd1);
    chk("leg_sck0",  32'(spi_sck), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(REG_CS, v); m_sck = 1'b1;
      chk("leg_sck_hi", 32'(spi_sck), 32'd1);
      miso_bit = (i % 2 == 0);
      d = 8'($urandom);
      wr(REG_DATA, d);
      if (m_sck) m_lsh = {m_lsh[5:0], miso_bit};
      m_sck = 1'b0;
      chk("leg_mosi", 32'(spi_mosi), 32'(d[7]));
      chk("leg_sck_lo", 32'(spi_sck), 32'd0);
    end
    miso_bit = 1'b1;
    rd(REG_DATA, v); m_sck = 1'b1;
    chk("leg_rd_55", 32'(v), 32'h55);
    chk("leg_rd_model", 32'(v), 32'({m_lsh, 1'b1}));
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin rd(REG_CS, v); m_sck = 1'b1; end
      miso_bit = 1'($urandom);
      d = 8'($urandom);
      wr(REG_DATA, d);
      if (m_sck) m_lsh = {m_lsh[5:0], miso_bit};
      m_sck = 1'b0;
      chk("leg_rnd_mosi", 32'(spi_mosi), 32'(d[7]));
    end
    miso_bit = 1'($urandom);
    rd(REG_DATA, v); m_sck = 1'b1;
    chk("leg_rnd_rd", 32'(v), 32'({m_lsh, miso_bit}));

    // Chip selects
    wr(REG_CS, 8'h02); cur_cs = 4'b0010;
    chk("cs_n_02", 32'(spi_cs_n), 32'h1);
    rd(REG_CS, v); chk("cs_rd", 32'(v), 32'h02);

    // Enter hardware mode; legacy sck was high and must drop
    wr(REG_CTRL, 8'h01);
    chk("mode_sck0", 32'(spi_sck), 32'd0);
    rd(REG_CTRL, v); chk("mode_rd", 32'(v), 32'h01);

    // div=0 loopback
    wr(REG_DIV, 8'h00);
    hw_xfer("hw_c3", 8'd0, 8'hC3, 8'h00, 1'b1, 1'b0);

    // div=24 with writes attempted while busy
    wr(REG_DIV, 8'd24);
    m = 8'($urandom);
    rise_base = rise_total; slave_tx = m; miso_sel = 2'd1;
    wr(REG_DATA, 8'h5A);
    t0 = cyc;
    repeat (3) @(posedge clk50mhz); #1;
    wr(REG_DATA, 8'hFF);
    wr(REG_DIV, 8'h00);
    wr(REG_CTRL, 8'h00);
    wr(REG_CS, 8'h01);
    chk("busy_cs_n", 32'(spi_cs_n), 32'h2);
    rd(REG_CS, v);   chk("busy_rd_cs", 32'(v), 32'hC1);
    rd(REG_DIV, v);  chk("busy_div_kept", 32'(v), 32'd24);
    rd(REG_CTRL, v); chk("busy_ctrl_kept", 32'(v), 32'h01);
    wait_idle("hw_5a", t1);
    chk("hw_5a_cycles", t1 - t0, 32'd400);
    chk("hw_5a_mosi", 32'(slave_rx), 32'h5A);
    rd(REG_DATA, v); chk("hw_5a_rx", 32'(v), 32'(m));
    miso_sel = 2'd0;
    wr(REG_CS, 8'h02);

    // Randomized byte transfers against the slave model
    last_rx = m;
    for (int i = 0; i < 4; i++) begin
      dv = 8'($urandom_range(0, 5));
      wr(REG_DIV, dv);
      d = 8'($urandom);
      m = 8'($urandom);
      hw_xfer("hw_rnd", dv, d, m, 1'b0, 1'b0);
      last_rx = m;
    end

    // Mode round-trip keeps both shift registers
    wr(REG_CTRL, 8'h00);
    miso_bit = 1'b0;
    rd(REG_DATA, v); chk("keep_leg", 32'(v), 32'({m_lsh, 1'b0}));
    wr(REG_CTRL, 8'h01);
    rd(REG_DATA, v); chk("keep_hw", 32'(v), 32'(last_rx));

    // Interrupt enable
    wr(REG_CTRL, 8'h03);
    rd(REG_CTRL, v); chk("ien_rd", 32'(v), 32'({6'd0, IRQ_EN, 1'b1}));
    wr(REG_DIV, 8'd1);
    hw_xfer("irq_3c", 8'd1, 8'h3C, 8'($urandom), 1'b0, IRQ_EN);

    // Asynchronous reset mid-transfer
    wr(REG_DIV, 8'd3);
    wr(REG_DATA, 8'hA5);
    repeat (20) @(posedge clk50mhz); #1;
    chk("mid_busy", 32'(bus_if.busy), 32'd1);
    #4 reset = 1'b1;
    #1;
    chk("mid_rst_sck",  32'(spi_sck), 32'd0);
    chk("mid_rst_mosi", 32'(spi_mosi), 32'd1);
    chk("mid_rst_cs_n", 32'(spi_cs_n), 32'h3);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_irq",  32'(bus_if.irq), 32'd0);
    @(posedge clk50mhz); #1 reset = 1'b0;
    rd(REG_DIV, v);  chk("post_rst_div", 32'(v), 32'd24);
    rd(REG_CTRL, v); chk("post_rst_ctrl", 32'(v), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rk_spi_port.md
Name: rk_spi_port

Overview:
- Parametrised SPI master for the 0xA000 I/O window; drives the SD card and up to CS_COUNT further SPI devices.
- Two modes:
  - Legacy bit-bang mode: bit-compatible with the existing SD interface, so current BIOS/SD loaders run unmodified.
  - Hardware byte mode: one CPU write shifts a full byte at a programmable SCK rate.
- Sits between the CPU bus decode and the SD/SPI pins; read data goes to the top-level cpu_i mux.

Parameters:
- CS_COUNT, 1, number of chip-select outputs (1..4).
- DIV_RESET, 8'd24, reset value of the divider register (SCK half-period = DIV+1 clk50mhz cycles, about 1 MHz).

Ports:
- clk50mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- addr  in  2  addrbus[1:0].
- we_n  in  1  active-low write strobe, already decoded for the window (ppa2_we_n).
- bus_rd  in  1  CPU read cycle indicator, ungated by address (cpu_rd); legacy SCK-high source.
- idata  in  8  CPU write data.
- odata  out  8  register read data, combinational from addr.
- busy  out  1  hardware transfer in progress.
- irq  out  1  transfer-done interrupt level.
- spi_miso  in  1  serial in.
- spi_mosi  out  1  serial out.
- spi_sck  out  1  serial clock (mode 0, CPOL=0).
- spi_cs_n  out  CS_COUNT  active-low selects.

Behaviour:
- Reset values: spi_sck=0, spi_mosi=1, spi_cs_n all 1, busy=0, irq=0, mode=0, div=DIV_RESET, shift register 0, done=0.
- Register map:
  - 0 CS: write bits[CS_COUNT-1:0], 1 = selected. Read {busy, mode, done, 0, cs padded to 4 bits}.
  - 1 DATA: behaviour depends on mode (see below).
  - 2 CTRL: bit0 = mode.
  - 3 DIV: 8-bit divider.
- A write occurs on any clk50mhz edge with we_n=0. The CPU holds we_n low for one cpu_ce period; all write side-effects must be idempotent under a repeated strobe.
- Legacy mode (mode=0), write DATA:
  - spi_mosi <= idata[7]; spi_sck <= 0.
  - If spi_sck was 1: legacy shift <= {shift[5:0], spi_miso}.
- Legacy mode, bus_rd=1 with no write that cycle: spi_sck <= 1. A write takes priority over bus_rd in the same cycle.
- Legacy mode, read DATA: {shift[6:0], spi_miso} (live pin).
- Hardware mode FSM, states IDLE, LOW, HIGH:
  - IDLE: a DATA write latches tx=idata and sets spi_mosi=idata[7], bitcnt=0, cnt=div, busy=1, done=0; go to LOW. Only the first write cycle is accepted; repeated strobe cycles are ignored while busy.
  - LOW: cnt decrements to 0, then spi_sck=1 and rx <= {rx[6:0], spi_miso}; reload cnt; go to HIGH.
  - HIGH: cnt decrements to 0, then spi_sck=0.
    - If bitcnt=7: busy=0, done=1; go to IDLE.
    - Otherwise: bitcnt+1, spi_mosi = next tx bit (MSB first); go to LOW.
  - Byte time = 16*(div+1) cycles; busy falls exactly 16*(div+1) cycles after the accepting edge.
- Hardware mode, read DATA returns rx. The first read cycle clears done.
- Writes while busy: DATA, CTRL and DIV writes are ignored. CS writes take effect immediately.
- Mode switch (only when idle):
  - spi_sck forced 0.
  - The legacy shift register and rx are independent and both preserved.
- div=0 gives SCK at 25 MHz (half-period 1 cycle). All 8-bit counts wrap naturally; no illegal values.
- Reset asserted mid-transfer returns the FSM to IDLE immediately and deselects all CS. The partial byte is lost.

Optional Feature:
- RK_SPI_IRQ_EN defined:
  - irq = done & ien, where ien = CTRL bit1 (reset 0).
  - Reading DATA clears irq.
- Undefined: irq tied 0, CTRL bit1 reads 0, no ien flop.

Decomposition:
- Shared package rk_spi_pkg holds:
  - register offsets REG_CS=0, REG_DATA=1, REG_CTRL=2, REG_DIV=3;
  - the FSM state encoding;
  - the MODE_LEGACY/MODE_HW constants.
- One natural sub-module, rk_spi_shifter: the hardware FSM, divider and shift registers. Register decode and legacy logic stay in the parent.

Test Plan:
- Reset mid-transfer (mode=1, div=3, write DATA=0xA5, assert reset after 20 cycles) -> sck=0, mosi=1, cs_n=all 1, busy=0 within the same cycle.
- Legacy: write DATA 0x80, pulse bus_rd, write DATA 0x00 with miso=1, repeat 7 times with miso alternating 1,0,… -> mosi follows bit7; read DATA returns {0x55 shifted pattern, live miso}.
- HW mode, div=0, loopback (miso=mosi), write DATA=0xC3 -> 8 SCK pulses, busy for exactly 16 cycles, read DATA=0xC3, done set then cleared by read.
- HW mode, div=24, write DATA=0x5A, then write DATA=0xFF and DIV=0 while busy -> second byte ignored, rx=miso pattern of 0x5A transfer, DIV still 24, transfer takes 400 cycles.
- CS_COUNT=2: write CS=0x02 -> spi_cs_n=2'b01; read CS reflects busy/mode/done bits.
- With RK_SPI_IRQ_EN and ien=1: transfer 0x3C completes -> irq=1; read DATA -> irq=0 next cycle. Without the macro -> irq stays 0.
